// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Captures one trace record per committed instruction from the CPU debug port,
// buffers the records in a small first-word-fall-through FIFO and drains them
// over a valid/ready stream to the trace checker. The core is never stalled:
// a commit that arrives while the FIFO is full and not being drained is
// dropped, which sets a sticky overflow flag. Every commit, dropped or not,
// consumes a sequence number, so drops also show up as gaps in trace_seq.
//
// Ports:
//   clock, reset         single clock, asynchronous active-low reset
//   debug_*              commit record from the CPU (sampled when debug_commit)
//   trace_valid/ready    head-of-FIFO handshake
//   trace_*              head record fields (meaningful only while valid)
//   trace_overflow       sticky: at least one record was dropped
//   fifo_count           current occupancy, 0..DEPTH
//   drop_count           saturating count of dropped records (optional)
//
// Configuration macro:
//   TRACE_DROP_CNT_EN    when defined, adds the drop_count[15:0] output.
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             debug_commit,
  input  logic [63:0]      debug_pc,
  input  logic [4:0]       debug_rf_wnum,
  input  logic [63:0]      debug_rf_wdata,
  input  logic [7:0]       debug_sram_wen,
  input  logic [31:0]      debug_sram_waddr,
  input  logic [63:0]      debug_sram_wdata,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [63:0]      trace_pc,
  output logic [4:0]       trace_wnum,
  output logic [63:0]      trace_wdata,
  output logic [7:0]       trace_sram_wen,
  output logic [31:0]      trace_sram_waddr,
  output logic [63:0]      trace_sram_wdata,
  output logic [SEQ_W-1:0] trace_seq,
  output logic             trace_overflow,
  output logic [CW-1:0]    fifo_count
`ifdef TRACE_DROP_CNT_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  typedef struct packed {
    logic [63:0]      pc;
    logic [4:0]       wnum;
    logic [63:0]      wdata;
    logic [7:0]       sram_wen;
    logic [31:0]      sram_waddr;
    logic [63:0]      sram_wdata;
    logic [SEQ_W-1:0] seq;
  } record_t;

  record_t          mem_q [DEPTH];
  record_t          rec_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_q;
  logic             overflow_q;

  logic full, pop, push, drop;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && trace_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push = debug_commit && (!full || pop);
  assign drop = debug_commit && full && !pop;

  // Canonicalise the record so the checker never sees stale data on fields
  // that carry no architectural effect (x0 writes, non-store instructions).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rec_d            = '0;
    rec_d.pc         = debug_pc;
    rec_d.wnum       = debug_rf_wnum;
    rec_d.sram_wen   = debug_sram_wen;
    rec_d.seq        = seq_q;
    if (debug_rf_wnum != 5'd0) rec_d.wdata = debug_rf_wdata;
    if (debug_sram_wen != 8'd0) begin
      rec_d.sram_waddr = debug_sram_waddr;
      rec_d.sram_wdata = debug_sram_wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (debug_commit) seq_q <= seq_q + SEQ_W'(1);
      if (drop)         overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count gates visibility, so stale
  // entries are never presented as valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= rec_d;
  end

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign trace_valid      = (count_q != '0);
  assign trace_pc         = mem_q[rd_ptr_q].pc;
  assign trace_wnum       = mem_q[rd_ptr_q].wnum;
  assign trace_wdata      = mem_q[rd_ptr_q].wdata;
  assign trace_sram_wen   = mem_q[rd_ptr_q].sram_wen;
  assign trace_sram_waddr = mem_q[rd_ptr_q].sram_waddr;
  assign trace_sram_wdata = mem_q[rd_ptr_q].sram_wdata;
  assign trace_seq        = mem_q[rd_ptr_q].seq;
  assign trace_overflow   = overflow_q;
  assign fifo_count       = count_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Directed testbench for commit_trace_buffer (DEPTH=8, SEQ_W=32). Inputs are
// driven and outputs sampled on the falling clock edge. When
// TRACE_DROP_CNT_EN is defined the drop_count output is connected and checked.
// -----------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        debug_commit;
  logic [63:0] debug_pc;
  logic [4:0]  debug_rf_wnum;
  logic [63:0] debug_rf_wdata;
  logic [7:0]  debug_sram_wen;
  logic [31:0] debug_sram_waddr;
  logic [63:0] debug_sram_wdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [63:0] trace_pc;
  logic [4:0]  trace_wnum;
  logic [63:0] trace_wdata;
  logic [7:0]  trace_sram_wen;
  logic [31:0] trace_sram_waddr;
  logic [63:0] trace_sram_wdata;
  logic [31:0] trace_seq;
  logic        trace_overflow;
  logic [3:0]  fifo_count;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .debug_commit     (debug_commit),
    .debug_pc         (debug_pc),
    .debug_rf_wnum    (debug_rf_wnum),
    .debug_rf_wdata   (debug_rf_wdata),
    .debug_sram_wen   (debug_sram_wen),
    .debug_sram_waddr (debug_sram_waddr),
    .debug_sram_wdata (debug_sram_wdata),
    .trace_valid      (trace_valid),
    .trace_ready      (trace_ready),
    .trace_pc         (trace_pc),
    .trace_wnum       (trace_wnum),
    .trace_wdata      (trace_wdata),
    .trace_sram_wen   (trace_sram_wen),
    .trace_sram_waddr (trace_sram_waddr),
    .trace_sram_wdata (trace_sram_wdata),
    .trace_seq        (trace_seq),
    .trace_overflow   (trace_overflow),
    .fifo_count       (fifo_count)
`ifdef TRACE_DROP_CNT_EN
    ,
    .drop_count       (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clock);
  endtask

  task automatic drive(input logic [63:0] pc, input logic [4:0] wn, input logic [63:0] wd,
                       input logic [7:0] wen, input logic [31:0] wa, input logic [63:0] sd);
    debug_commit     = 1'b1;
    debug_pc         = pc;
    debug_rf_wnum    = wn;
    debug_rf_wdata   = wd;
    debug_sram_wen   = wen;
    debug_sram_waddr = wa;
    debug_sram_wdata = sd;
  endtask

  // Asserts reset between clock edges, checks the outputs clear immediately,
  // and releases it on the following falling edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_valid"},    64'(trace_valid),    64'd0);
    check({tag, "_count"},    64'(fifo_count),     64'd0);
    check({tag, "_overflow"}, 64'(trace_overflow), 64'd0);
`ifdef TRACE_DROP_CNT_EN
    check({tag, "_dropcnt"},  64'(drop_count),     64'd0);
`endif
    next();
    reset = 1'b1;
  endtask

  function automatic logic [63:0] wrap_pc(input int s);
    return 64'h4000 + 64'(s) * 64'd4;
  endfunction

  function automatic logic [63:0] wrap_wd(input int s);
    return {32'(s), ~32'(s)};
  endfunction

  int exp_q[$];
  int sent;
  logic do_commit;

  initial begin
    reset        = 1'b0;
    trace_ready  = 1'b0;
    debug_commit = 1'b0;
    drive(64'd0, 5'd0, 64'd0, 8'd0, 32'd0, 64'd0);
    debug_commit = 1'b0;

    // Reset state, then idle.
    next();
    check("rst_valid", 64'(trace_valid), 64'd0);
    check("rst_count", 64'(fifo_count),  64'd0);
    check("rst_ovf",   64'(trace_overflow), 64'd0);
    next();
    reset = 1'b1;
    repeat (10) next();
    check("idle_valid", 64'(trace_valid), 64'd0);
    check("idle_count", 64'(fifo_count),  64'd0);

    // Single commit, then pop it.
    drive(64'h8000_0000, 5'd5, 64'h1234, 8'd0, 32'd0, 64'd0);
    next();
    debug_commit = 1'b0;
    check("one_valid", 64'(trace_valid), 64'd1);
    check("one_pc",    trace_pc,         64'h8000_0000);
    check("one_wnum",  64'(trace_wnum),  64'd5);
    check("one_wdata", trace_wdata,      64'h1234);
    check("one_seq",   64'(trace_seq),   64'd0);
    check("one_count", 64'(fifo_count),  64'd1);
    trace_ready = 1'b1;
    next();
    trace_ready = 1'b0;
    check("one_pop_valid", 64'(trace_valid), 64'd0);
    check("one_pop_count", 64'(fifo_count),  64'd0);

    // Canonicalisation: x0 write and non-store.
    drive(64'h10, 5'd0, 64'hDEAD, 8'd0, 32'h100, 64'hBEEF);
    next();
    debug_commit = 1'b0;
    check("canon_wnum",  64'(trace_wnum),       64'd0);
    check("canon_wdata", trace_wdata,           64'd0);
    check("canon_wen",   64'(trace_sram_wen),   64'd0);
    check("canon_waddr", 64'(trace_sram_waddr), 64'd0);
    check("canon_sdata", trace_sram_wdata,      64'd0);
    check("canon_seq",   64'(trace_seq),        64'd1);
    // Store record pushed while the single entry is popped (count==1 case).
    drive(64'h14, 5'd3, 64'h77, 8'h0F, 32'h200, 64'hAB);
    trace_ready = 1'b1;
    next();
    debug_commit = 1'b0;
    trace_ready  = 1'b0;
    check("st_count", 64'(fifo_count),       64'd1);
    check("st_pc",    trace_pc,              64'h14);
    check("st_seq",   64'(trace_seq),        64'd2);
    check("st_wdata", trace_wdata,           64'h77);
    check("st_wen",   64'(trace_sram_wen),   64'h0F);
    check("st_waddr", 64'(trace_sram_waddr), 64'h200);
    check("st_sdata", trace_sram_wdata,      64'hAB);
    trace_ready = 1'b1;
    next();
    trace_ready = 1'b0;
    check("st_drain", 64'(fifo_count), 64'd0);

    // Reset mid-stream drops buffered records and restarts the sequence.
    drive(64'h20, 5'd1, 64'h1, 8'd0, 32'd0, 64'd0);
    next();
    next();
    debug_commit = 1'b0;
    check("mid_count", 64'(fifo_count), 64'd2);
    do_reset("mid");
    repeat (10) next();
    check("mid_idle_valid", 64'(trace_valid), 64'd0);
    check("mid_idle_count", 64'(fifo_count),  64'd0);
    drive(64'h30, 5'd1, 64'h1, 8'd0, 32'd0, 64'd0);
    next();
    debug_commit = 1'b0;
    check("mid_seq0", 64'(trace_seq), 64'd0);
    trace_ready = 1'b1;
    next();
    trace_ready = 1'b0;

    // Full FIFO with simultaneous push and pop: seq 1..8 fill, seq 9 enters.
    for (int i = 0; i < DEPTH; i++) begin
      drive(64'h2000 + 64'(i), 5'd2, 64'(i), 8'd0, 32'd0, 64'd0);
      next();
    end
    debug_commit = 1'b0;
    check("full_count", 64'(fifo_count), 64'd8);
    check("full_head",  64'(trace_seq),  64'd1);
    drive(64'h2100, 5'd2, 64'h99, 8'd0, 32'd0, 64'd0);
    trace_ready = 1'b1;
    next();
    debug_commit = 1'b0;
    trace_ready  = 1'b0;
    check("fpp_count", 64'(fifo_count),     64'd8);
    check("fpp_seq",   64'(trace_seq),      64'd2);
    check("fpp_pc",    trace_pc,            64'h2001);
    check("fpp_ovf",   64'(trace_overflow), 64'd0);
    trace_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("fpp_drain_seq", 64'(trace_seq), 64'(k + 2));
      check("fpp_drain_pc",  trace_pc, (k == 7) ? 64'h2100 : 64'h2000 + 64'(k + 1));
      next();
    end
    trace_ready = 1'b0;
    check("fpp_empty", 64'(trace_valid), 64'd0);

    // Overflow: 10 commits into an undrained FIFO.
    do_reset("ovr");
    for (int i = 0; i < 10; i++) begin
      drive(64'h1000 + 64'(i), 5'(i + 1), 64'(i), 8'd0, 32'd0, 64'd0);
      next();
      check("ovf_count", 64'(fifo_count), (i < DEPTH) ? 64'(i + 1) : 64'd8);
      if (i == 7) check("ovf_before", 64'(trace_overflow), 64'd0);
      if (i == 8) check("ovf_after",  64'(trace_overflow), 64'd1);
    end
    debug_commit = 1'b0;
`ifdef TRACE_DROP_CNT_EN
    check("ovf_dropcnt", 64'(drop_count), 64'd2);
`endif
    trace_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("ovf_drain_seq",   64'(trace_seq), 64'(k));
      check("ovf_drain_pc",    trace_pc,       64'h1000 + 64'(k));
      check("ovf_drain_wdata", trace_wdata,    64'(k));
      next();
    end
    trace_ready = 1'b0;
    check("ovf_empty", 64'(trace_valid), 64'd0);
    drive(64'h1100, 5'd1, 64'h5, 8'd0, 32'd0, 64'd0);
    next();
    debug_commit = 1'b0;
    check("ovf_next_seq", 64'(trace_seq),      64'd10);
    check("ovf_sticky",   64'(trace_overflow), 64'd1);
    trace_ready = 1'b1;
    next();
    trace_ready = 1'b0;

    // Wrap-around: 24 commits with ready every other cycle, scoreboarded.
    do_reset("wrap");
    sent = 0;
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (exp_q.size() > 0) begin
        check("wrap_valid", 64'(trace_valid), 64'd1);
        check("wrap_seq",   64'(trace_seq),   64'(exp_q[0]));
        check("wrap_pc",    trace_pc,         wrap_pc(exp_q[0]));
        check("wrap_wdata", trace_wdata,      wrap_wd(exp_q[0]));
        check("wrap_waddr", 64'(trace_sram_waddr), 64'(exp_q[0]));
      end
      check("wrap_count", 64'(fifo_count), 64'(exp_q.size()));
      do_commit = (cyc % 3 != 2) && (sent < 3 * DEPTH);
      trace_ready = (cyc % 2 == 1);
      if (do_commit)
        drive(wrap_pc(sent), 5'(sent) | 5'd1, wrap_wd(sent), 8'hFF, 32'(sent), ~wrap_pc(sent));
      else
        debug_commit = 1'b0;
      if (trace_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (do_commit) begin
        exp_q.push_back(sent);
        sent++;
      end
      next();
    end
    debug_commit = 1'b0;
    trace_ready  = 1'b0;
    check("wrap_sent",  64'(sent),           64'(3 * DEPTH));
    check("wrap_empty", 64'(fifo_count),     64'd0);
    check("wrap_ovf",   64'(trace_overflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
